// File: rtl/br_rs.sv
// Branch reservation station: a compacting queue of branch/jump entries that
// wait for their regA operand and issue oldest-ready-first to the branch FU.
//
// Handshake: fu_ready_i is sampled in the cycle an entry is selected. A
// selection happens only when fu_ready_i=1. start_o is a registered one-cycle
// pulse that carries the selected entry in the following cycle. The FU has no
// stall path once a pulse has been seen. The dispatcher must not raise
// disp_en_i while full_o=1; such a dispatch is dropped.
module br_rs #(
    parameter int RS_DEPTH  = 4,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           disp_en_i,
    input  logic [63:0]                    disp_npc_i,
    input  logic [31:0]                    disp_inst_i,
    input  logic [PRF_IDX_W-1:0]           disp_dest_tag_i,
    input  logic [ROB_IDX_W:0]             disp_rob_idx_i,
    input  logic [PRF_IDX_W-1:0]           disp_opa_tag_i,
    input  logic                           disp_opa_rdy_i,
    input  logic [63:0]                    disp_opa_val_i,
    input  logic                           cdb_valid_i,
    input  logic [PRF_IDX_W-1:0]           cdb_tag_i,
    input  logic [63:0]                    cdb_val_i,
    input  logic                           flush_i,
    input  logic                           fu_ready_i,
    output logic                           full_o,
    output logic [$clog2(RS_DEPTH+1)-1:0]  count_o,
    output logic                           start_o,
    output logic [63:0]                    npc_o,
    output logic [63:0]                    opa_o,
    output logic [31:0]                    inst_o,
    output logic [PRF_IDX_W-1:0]           dest_tag_o,
    output logic [ROB_IDX_W:0]             rob_idx_o
);

    localparam int CNT_W = $clog2(RS_DEPTH + 1);
    localparam int IDX_W = $clog2(RS_DEPTH);

    typedef struct packed {
        logic                 valid;
        logic [63:0]          npc;
        logic [31:0]          inst;
        logic [PRF_IDX_W-1:0] dest_tag;
        logic [ROB_IDX_W:0]   rob_idx;
        logic [PRF_IDX_W-1:0] opa_tag;
        logic                 opa_rdy;
        logic [63:0]          opa_val;
    } entry_t;

    entry_t             rs_q     [RS_DEPTH];
    entry_t             rs_snoop [RS_DEPTH];
    entry_t             rs_d     [RS_DEPTH];
    entry_t             new_ent;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   wr_cnt;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               issue;

    // Occupancy from the registered valid bits only (entries are contiguous).
    always_comb begin
        count = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            count = count + CNT_W'(rs_q[i].valid);
        end
    end

    assign count_o = count;
    assign full_o  = (count == CNT_W'(RS_DEPTH));

    // Oldest-ready select on registered state; CDB does not bypass into it.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!sel_found && rs_q[i].valid && rs_q[i].opa_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign issue = fu_ready_i && !flush_i && sel_found;

    // CDB snoop applied before the shift so a woken entry keeps its wakeup
    // wherever it lands.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            rs_snoop[i] = rs_q[i];
            if (rs_q[i].valid && !rs_q[i].opa_rdy && cdb_valid_i &&
                (rs_q[i].opa_tag == cdb_tag_i)) begin
                rs_snoop[i].opa_rdy = 1'b1;
                rs_snoop[i].opa_val = cdb_val_i;
            end
        end
    end

    // New entry, with wakeup from a CDB broadcast in the same cycle.
    always_comb begin
        new_ent          = '0;
        new_ent.valid    = 1'b1;
        new_ent.npc      = disp_npc_i;
        new_ent.inst     = disp_inst_i;
        new_ent.dest_tag = disp_dest_tag_i;
        new_ent.rob_idx  = disp_rob_idx_i;
        new_ent.opa_tag  = disp_opa_tag_i;
        new_ent.opa_rdy  = disp_opa_rdy_i;
        new_ent.opa_val  = disp_opa_val_i;
        if (!disp_opa_rdy_i && cdb_valid_i && (cdb_tag_i == disp_opa_tag_i)) begin
            new_ent.opa_rdy = 1'b1;
            new_ent.opa_val = cdb_val_i;
        end
    end

    // Next queue: remove the issued entry by shifting down, then append the
    // dispatch behind the surviving entries.
    always_comb begin
        for (int i = 0; i < RS_DEPTH - 1; i++) begin
            if (issue && (i >= int'(sel_idx))) begin
                rs_d[i] = rs_snoop[i+1];
            end else begin
                rs_d[i] = rs_snoop[i];
            end
        end
        rs_d[RS_DEPTH-1] = issue ? '0 : rs_snoop[RS_DEPTH-1];
        wr_cnt = count - CNT_W'(issue);
        if (disp_en_i && !full_o) begin
            rs_d[IDX_W'(wr_cnt)] = new_ent;
        end
    end

    // State and issue registers; rst beats flush, flush beats everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                rs_q[i] <= '0;
            end
            start_o    <= 1'b0;
            npc_o      <= '0;
            opa_o      <= '0;
            inst_o     <= '0;
            dest_tag_o <= '0;
            rob_idx_o  <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                rs_q[i] <= '0;
            end
            start_o <= 1'b0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                rs_q[i] <= rs_d[i];
            end
            start_o <= issue;
            if (issue) begin
                npc_o      <= rs_q[sel_idx].npc;
                opa_o      <= rs_q[sel_idx].opa_val;
                inst_o     <= rs_q[sel_idx].inst;
                dest_tag_o <= rs_q[sel_idx].dest_tag;
                rob_idx_o  <= rs_q[sel_idx].rob_idx;
            end
        end
    end

endmodule

// File: tb/tb_br_rs.sv
// Self-checking bench for br_rs: directed scenarios plus a randomized phase,
// all checked every cycle against a queue-based reference model.
module tb_br_rs;

    localparam int RS_DEPTH  = 4;
    localparam int PRF_IDX_W = 6;
    localparam int ROB_IDX_W = 5;
    localparam int CNT_W     = $clog2(RS_DEPTH + 1);

    logic                 clk;
    logic                 rst;
    logic                 disp_en_i;
    logic [63:0]          disp_npc_i;
    logic [31:0]          disp_inst_i;
    logic [PRF_IDX_W-1:0] disp_dest_tag_i;
    logic [ROB_IDX_W:0]   disp_rob_idx_i;
    logic [PRF_IDX_W-1:0] disp_opa_tag_i;
    logic                 disp_opa_rdy_i;
    logic [63:0]          disp_opa_val_i;
    logic                 cdb_valid_i;
    logic [PRF_IDX_W-1:0] cdb_tag_i;
    logic [63:0]          cdb_val_i;
    logic                 flush_i;
    logic                 fu_ready_i;
    logic                 full_o;
    logic [CNT_W-1:0]     count_o;
    logic                 start_o;
    logic [63:0]          npc_o;
    logic [63:0]          opa_o;
    logic [31:0]          inst_o;
    logic [PRF_IDX_W-1:0] dest_tag_o;
    logic [ROB_IDX_W:0]   rob_idx_o;

    br_rs #(
        .RS_DEPTH(RS_DEPTH), .PRF_IDX_W(PRF_IDX_W), .ROB_IDX_W(ROB_IDX_W)
    ) dut (
        .clk(clk), .rst(rst),
        .disp_en_i(disp_en_i), .disp_npc_i(disp_npc_i), .disp_inst_i(disp_inst_i),
        .disp_dest_tag_i(disp_dest_tag_i), .disp_rob_idx_i(disp_rob_idx_i),
        .disp_opa_tag_i(disp_opa_tag_i), .disp_opa_rdy_i(disp_opa_rdy_i),
        .disp_opa_val_i(disp_opa_val_i),
        .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_val_i(cdb_val_i),
        .flush_i(flush_i), .fu_ready_i(fu_ready_i),
        .full_o(full_o), .count_o(count_o), .start_o(start_o),
        .npc_o(npc_o), .opa_o(opa_o), .inst_o(inst_o),
        .dest_tag_o(dest_tag_o), .rob_idx_o(rob_idx_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0]          npc;
        logic [31:0]          inst;
        logic [PRF_IDX_W-1:0] dest;
        logic [ROB_IDX_W:0]   rob;
        logic [PRF_IDX_W-1:0] tag;
        bit                   rdy;
        logic [63:0]          val;
    } m_ent_t;

    m_ent_t               mq[$];
    bit                   m_start;
    logic [63:0]          m_npc, m_opa;
    logic [31:0]          m_inst;
    logic [PRF_IDX_W-1:0] m_dest;
    logic [ROB_IDX_W:0]   m_rob;

    // scoreboard of rob indices expected to issue, in order
    logic [ROB_IDX_W:0]   exp_q[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of the model, evaluated from the inputs sampled at the edge.
    task automatic model_step();
        int     pre;
        int     sel;
        m_ent_t e;
        if (rst) begin
            mq.delete();
            m_start = 0; m_npc = '0; m_opa = '0; m_inst = '0; m_dest = '0; m_rob = '0;
            return;
        end
        if (flush_i) begin
            mq.delete();
            m_start = 0;
            return;
        end
        pre = mq.size();
        sel = -1;
        if (fu_ready_i) begin
            foreach (mq[i]) begin
                if (sel < 0 && mq[i].rdy) sel = i;
            end
        end
        m_start = (sel >= 0);
        if (sel >= 0) begin
            m_npc  = mq[sel].npc;
            m_opa  = mq[sel].val;
            m_inst = mq[sel].inst;
            m_dest = mq[sel].dest;
            m_rob  = mq[sel].rob;
        end
        foreach (mq[i]) begin
            if (!mq[i].rdy && cdb_valid_i && mq[i].tag == cdb_tag_i) begin
                mq[i].rdy = 1;
                mq[i].val = cdb_val_i;
            end
        end
        if (sel >= 0) mq.delete(sel);
        if (disp_en_i && pre < RS_DEPTH) begin
            e.npc  = disp_npc_i;
            e.inst = disp_inst_i;
            e.dest = disp_dest_tag_i;
            e.rob  = disp_rob_idx_i;
            e.tag  = disp_opa_tag_i;
            e.rdy  = disp_opa_rdy_i;
            e.val  = disp_opa_val_i;
            if (!disp_opa_rdy_i && cdb_valid_i && cdb_tag_i == disp_opa_tag_i) begin
                e.rdy = 1;
                e.val = cdb_val_i;
            end
            mq.push_back(e);
        end
    endtask

    task automatic check_all();
        check("start",    64'(start_o),    64'(m_start));
        check("count",    64'(count_o),    64'(mq.size()));
        check("full",     64'(full_o),     64'(mq.size() == RS_DEPTH));
        check("npc",      npc_o,           m_npc);
        check("opa",      opa_o,           m_opa);
        check("inst",     64'(inst_o),     64'(m_inst));
        check("dest_tag", 64'(dest_tag_o), 64'(m_dest));
        check("rob_idx",  64'(rob_idx_o),  64'(m_rob));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        rst = 0; disp_en_i = 0; disp_npc_i = '0; disp_inst_i = '0;
        disp_dest_tag_i = '0; disp_rob_idx_i = '0; disp_opa_tag_i = '0;
        disp_opa_rdy_i = 0; disp_opa_val_i = '0; cdb_valid_i = 0;
        cdb_tag_i = '0; cdb_val_i = '0; flush_i = 0; fu_ready_i = 0;
    endtask

    task automatic set_disp(input logic [63:0] npc, input logic [31:0] inst,
                            input logic [ROB_IDX_W:0] rob, input logic [PRF_IDX_W-1:0] tag,
                            input logic rdy, input logic [63:0] val);
        disp_en_i = 1; disp_npc_i = npc; disp_inst_i = inst;
        disp_dest_tag_i = PRF_IDX_W'(rob + 1); disp_rob_idx_i = rob;
        disp_opa_tag_i = tag; disp_opa_rdy_i = rdy; disp_opa_val_i = val;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();

        // reset then idle
        do_reset();
        repeat (5) begin
            cycle();
            check("idle_start", 64'(start_o), 64'd0);
            check("idle_count", 64'(count_o), 64'd0);
        end

        // ready dispatch
        fu_ready_i = 1;
        set_disp(64'h104, 32'hE420_0004, 6'd3, 6'd1, 1'b1, 64'd0);
        cycle();
        check("rd_count_e0", 64'(count_o), 64'd1);
        disp_en_i = 0;
        cycle();
        check("rd_start", 64'(start_o), 64'd1);
        check("rd_npc", npc_o, 64'h104);
        check("rd_rob", 64'(rob_idx_o), 64'd3);
        check("rd_count_e1", 64'(count_o), 64'd0);

        // out-of-order issue via CDB wakeup
        set_disp(64'h200, 32'hE420_0010, 6'd4, 6'd7, 1'b0, 64'd0);
        cycle();
        set_disp(64'h204, 32'hE420_0020, 6'd5, 6'd2, 1'b1, 64'd11);
        cycle();
        disp_en_i = 0;
        cdb_valid_i = 1; cdb_tag_i = 6'd7; cdb_val_i = 64'd5;
        cycle();
        check("ooo_first_rob", 64'(rob_idx_o), 64'd5);
        cdb_valid_i = 0;
        cycle();
        check("ooo_second_start", 64'(start_o), 64'd1);
        check("ooo_second_rob", 64'(rob_idx_o), 64'd4);
        check("ooo_second_opa", opa_o, 64'd5);

        // same-cycle dispatch wakeup
        set_disp(64'h300, 32'hE420_0030, 6'd6, 6'd9, 1'b0, 64'd0);
        cdb_valid_i = 1; cdb_tag_i = 6'd9; cdb_val_i = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle();
        disp_en_i = 0; cdb_valid_i = 0;
        cycle();
        check("wake_start", 64'(start_o), 64'd1);
        check("wake_opa", opa_o, 64'hFFFF_FFFF_FFFF_FFFF);

        // full and back-pressure
        fu_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            set_disp(64'h400 + 64'(i * 4), 32'hE420_0040, 6'(10 + i), 6'd3, 1'b1, 64'(i));
            exp_q.push_back(6'(10 + i));
            cycle();
        end
        set_disp(64'h500, 32'hE420_0050, 6'd14, 6'd3, 1'b1, 64'd99);
        cycle();
        check("bp_full", 64'(full_o), 64'd1);
        check("bp_count", 64'(count_o), 64'd4);
        disp_en_i = 0;
        fu_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("bp_start", 64'(start_o), 64'd1);
            if (exp_q.size() > 0) check("bp_order", 64'(rob_idx_o), 64'(exp_q.pop_front()));
        end
        cycle();
        check("bp_drained", 64'(start_o), 64'd0);

        // flush mid-operation
        fu_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            set_disp(64'h600 + 64'(i * 4), 32'hE420_0060, 6'(20 + i), 6'd4, 1'b1, 64'(i));
            cycle();
        end
        fu_ready_i = 1; flush_i = 1;
        set_disp(64'h700, 32'hE420_0070, 6'd30, 6'd4, 1'b1, 64'd7);
        cycle();
        check("fl_start", 64'(start_o), 64'd0);
        check("fl_count", 64'(count_o), 64'd0);
        flush_i = 0;
        set_disp(64'h800, 32'hE420_0080, 6'd31, 6'd4, 1'b1, 64'd8);
        cycle();
        disp_en_i = 0;
        cycle();
        check("fl_after_rob", 64'(rob_idx_o), 64'd31);

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            rst = ($urandom_range(0, 299) == 0);
            flush_i = ($urandom_range(0, 39) == 0);
            fu_ready_i = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 1) begin
                set_disp({$urandom, $urandom}, $urandom, 6'($urandom_range(0, 63)),
                         6'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0),
                         {$urandom, $urandom});
            end
            cdb_valid_i = ($urandom_range(0, 9) < 4);
            cdb_tag_i = 6'($urandom_range(0, 7));
            cdb_val_i = {$urandom, $urandom};
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
